// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load alignment/extension and writeback source selection.
// Drives the register-file write port and keeps a retired-instruction counter.
module mem_wb_stage #(
    parameter bit BIG_ENDIAN = 1'b0,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             in_reg_write,
    input  logic [1:0]       in_wb_sel,
    input  logic [4:0]       in_dst,
    input  logic [31:0]      in_alu_result,
    input  logic [31:0]      in_mem_rdata,
    input  logic [31:0]      in_pc_plus4,
    input  logic [1:0]       in_ld_size,
    input  logic             in_ld_unsigned,
    output logic             rf_wr,
    output logic [4:0]       rf_addr,
    output logic [31:0]      rf_data,
    output logic             wb_valid,
    output logic [CNT_W-1:0] retire_count
);

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_LINK = 2'b10,
        WB_RSVD = 2'b11
    } wb_sel_e;

    typedef enum logic [1:0] {
        LD_WORD     = 2'b00,
        LD_HALF     = 2'b01,
        LD_BYTE     = 2'b10,
        LD_WORD_ALT = 2'b11
    } ld_size_e;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        wb_sel_e     wb_sel;
        logic [4:0]  dst;
        logic [31:0] alu_result;
        logic [31:0] mem_rdata;
        logic [31:0] pc_plus4;
        ld_size_e    ld_size;
        logic        ld_unsigned;
    } stage_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    stage_t stage_q;
    stage_t stage_d;

    always_comb begin
        stage_d.valid       = in_valid;
        stage_d.reg_write   = in_reg_write;
        stage_d.wb_sel      = wb_sel_e'(in_wb_sel);
        stage_d.dst         = in_dst;
        stage_d.alu_result  = in_alu_result;
        stage_d.mem_rdata   = in_mem_rdata;
        stage_d.pc_plus4    = in_pc_plus4;
        stage_d.ld_size     = ld_size_e'(in_ld_size);
        stage_d.ld_unsigned = in_ld_unsigned;
    end

    // Flush beats stall; a flushed slot keeps stale payload but can never write or count.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q      <= '0;
            retire_count <= '0;
        end else if (flush) begin
            stage_q.valid     <= 1'b0;
            stage_q.reg_write <= 1'b0;
        end else if (!stall) begin
            stage_q <= stage_d;
            if (in_valid) begin
                retire_count <= retire_count + CNT_ONE;
            end
        end
    end

    logic [1:0]  lane;
    logic        half_hi;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_value;

    // Big-endian mirrors the lane index, which also inverts the half selection.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        lane     = stage_q.alu_result[1:0] ^ {2{BIG_ENDIAN}};
        half_hi  = stage_q.alu_result[1] ^ BIG_ENDIAN;
        ld_byte  = 8'h00;
        ld_half  = half_hi ? stage_q.mem_rdata[31:16] : stage_q.mem_rdata[15:0];
        ld_value = stage_q.mem_rdata;

        case (lane)
            2'd0:    ld_byte = stage_q.mem_rdata[7:0];
            2'd1:    ld_byte = stage_q.mem_rdata[15:8];
            2'd2:    ld_byte = stage_q.mem_rdata[23:16];
            default: ld_byte = stage_q.mem_rdata[31:24];
        endcase

        case (stage_q.ld_size)
            LD_HALF: ld_value = {{16{ld_half[15] & ~stage_q.ld_unsigned}}, ld_half};
            LD_BYTE: ld_value = {{24{ld_byte[7] & ~stage_q.ld_unsigned}}, ld_byte};
            default: ld_value = stage_q.mem_rdata;
        endcase
    end

    always_comb begin
        rf_data = 32'h0;
        case (stage_q.wb_sel)
            WB_ALU:  rf_data = stage_q.alu_result;
            WB_LOAD: rf_data = ld_value;
            WB_LINK: rf_data = stage_q.pc_plus4;
            default: rf_data = 32'h0;
        endcase
    end

    // A stalled writer keeps rf_wr high; the register file rewrites the same value.
    assign rf_wr    = stage_q.valid & stage_q.reg_write & (stage_q.dst != 5'd0)
                      & (stage_q.wb_sel != WB_RSVD);
    assign rf_addr  = stage_q.dst;
    assign wb_valid = stage_q.valid;

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus writeback logic for the pipelined MIPS core.
- Captures MEM-stage results on the rising edge, aligns and extends load data, and selects the writeback value (ALU / load / link).
- Drives the register file write port (wr, addr3, data3), which commits on the falling edge of the same cycle, so a same-cycle ID read sees the new value.
- Keeps a retired-instruction counter.

Parameters:
- BIG_ENDIAN, 0: byte-lane order for sub-word loads. 0 means byte k sits at bits [8k+7:8k]. 1 means the lane index is mirrored (3-k).
- CNT_W, 32: retire counter width. The counter wraps modulo 2^CNT_W.

Ports:
- clk  input  1  system clock; the stage register updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hold the stage register.
- flush  input  1  load a bubble instead of the incoming instruction.
- in_valid  input  1  MEM stage holds a real instruction.
- in_reg_write  input  1  instruction writes a GPR.
- in_wb_sel  input  2  writeback source: 00 ALU, 01 load, 10 link (PC+4), 11 reserved.
- in_dst  input  5  destination GPR. Upstream has already resolved rd/rt/$31.
- in_alu_result  input  32  ALU result / effective address.
- in_mem_rdata  input  32  raw word returned by data memory.
- in_pc_plus4  input  32  PC+4 of the instruction.
- in_ld_size  input  2  load size: 00 word, 01 half, 10 byte, 11 treated as word.
- in_ld_unsigned  input  1  zero-extend (lbu/lhu) when 1, sign-extend when 0.
- rf_wr  output  1  to register file wr.
- rf_addr  output  5  to register file addr3.
- rf_data  output  32  to register file data3.
- wb_valid  output  1  stage holds a real instruction; used by the forwarding unit.
- retire_count  output  CNT_W  instructions retired since reset.

Behaviour:
- Stage register contents: valid, reg_write, wb_sel, dst, alu_result, mem_rdata, pc_plus4, ld_size, ld_unsigned.
- Update priority at each rising edge, highest first:
  - reset: all fields cleared asynchronously, retire_count = 0.
  - flush: valid = 0, reg_write = 0, other fields don't-care.
  - stall: all fields hold.
  - otherwise: load all in_* fields.
- Simultaneous flush and stall: flush wins.
- Reset outputs: rf_wr = 0, rf_addr = 0, rf_data = 0, wb_valid = 0, retire_count = 0. Reset asserted mid-stall or mid-load clears immediately, without waiting for a clock edge.
- Latency: one cycle. Inputs sampled at edge N appear on rf_* after edge N and are written by the register file at the falling edge of cycle N.
- All outputs are combinational from the stage register only, with no input-to-output paths.
- rf_wr = valid & reg_write & (dst != 0) & (wb_sel != 11).
- rf_addr = dst.
- rf_data selection:
  - wb_sel 00: alu_result.
  - wb_sel 10: pc_plus4.
  - wb_sel 11: 32'h0.
  - wb_sel 01: aligned load value, built as below.
- Load alignment uses lane = alu_result[1:0], mirrored when BIG_ENDIAN = 1.
  - Word: mem_rdata unchanged. The low address bits are ignored.
  - Half: selects [15:0] when alu_result[1] = 0, else [31:16]. alu_result[0] is ignored, so a misaligned half is aligned down and no exception is raised. With BIG_ENDIAN = 1 the half selection is inverted.
  - Byte: selects the lane byte.
  - Extension: sign-extend from bit 7/15, or zero-extend when ld_unsigned = 1.
- Stall while holding a valid writing instruction: rf_wr stays asserted. The register file rewrites the same value, which is idempotent and required.
- retire_count increments by 1 at a rising edge when the register loads (no reset/flush/stall) and in_valid = 1.
  - A stalled instruction is counted once.
  - Bubbles and flushed instructions are not counted.
  - Wraps from all-ones to 0.
- The stage never stalls itself and has no back-pressure output.

Test Plan:
- Reset then idle: assert reset for 2 cycles mid-run with in_valid = 1 -> all outputs 0 during reset without waiting for a clock edge. After release, retire_count counts from 0.
- ALU writeback: in_valid=1, reg_write=1, wb_sel=00, dst=8, alu_result=0x1234_5678 -> next cycle rf_wr=1, rf_addr=8, rf_data=0x1234_5678, retire_count +1. Same with dst=0 -> rf_wr=0, count still +1.
- Loads, mem_rdata=0x80FF_7F01, BIG_ENDIAN=0:
  - lb, addr lo=3 -> 0xFFFF_FF80.
  - lbu, addr lo=3 -> 0x0000_0080.
  - lb, addr lo=1 -> 0x0000_007F.
  - lh, addr lo=2 -> 0xFFFF_80FF.
  - lhu, addr lo=0 -> 0x0000_7F01.
  - lh, addr lo=1 -> 0x0000_7F01 (aligned down).
- Link and reserved: wb_sel=10, dst=31, pc_plus4=0x0000_0104 -> rf_data=0x0000_0104, rf_wr=1. wb_sel=11 with reg_write=1 -> rf_wr=0, rf_data=0.
- Stall/flush:
  - Load an instruction with dst=5, then stall 3 cycles while inputs change -> outputs hold dst=5 and its data, count +1 only.
  - Assert stall and flush together -> wb_valid=0, rf_wr=0, count unchanged.
- Counter wrap (CNT_W=4): retire 17 valid instructions, interleaved with bubbles (in_valid=0) -> retire_count=1.
